keccak_combine: RTL and testbench

//  Write-side counterpart of the 512-bit->32-bit read splitter: assembles 32-bit words

---
 rtl/keccak_pkg.sv | 15 +
 rtl/keccak_combine.sv | 154 +++++++++++++++
 tb/tb_keccak_combine.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// Shared constants and FSM state encoding for the Keccak write-side block combiner.
package keccak_pkg;

    localparam int KECCAK_WORDS = 16;
    localparam int KECCAK_WW    = 32;
    localparam int KECCAK_BLK   = KECCAK_WORDS * KECCAK_WW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_ACK   = 2'd2,
        ST_DRAIN = 2'd3
    } kc_state_e;

endpackage

// File: rtl/keccak_combine.sv
// Assembles 32-bit custom-instruction writes into a 512-bit Keccak block and hands it off.
// Optional feature: define KECCAK_COMBINE_AUTOINC_EN for pointer-based auto-increment writes.
module keccak_combine
    import keccak_pkg::*;
#(
    parameter int WORDS = KECCAK_WORDS,
    parameter int WW    = KECCAK_WW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [5:0]            num,
    input  logic [WW-1:0]         in32,
    input  logic                  clr,
    input  logic                  go,
    input  logic                  core_busy,
    output logic [WORDS*WW-1:0]   out512,
    output logic [WORDS-1:0]      mask,
    output logic                  full,
    output logic                  start,
    output logic                  ready,
    output logic                  ovf
);

    localparam int IW = $clog2(WORDS);

    kc_state_e         state_q, state_d;
    logic [WW-1:0]     word_q [WORDS];
    logic [WW-1:0]     word_d [WORDS];
    logic [WORDS-1:0]  mask_q, mask_d;
    logic              full_q, full_d;
    logic              start_q, start_d;
    logic              ready_q, ready_d;
    logic              ovf_q, ovf_d;

    logic              idle;
    logic              clr_fire;
    logic              wr_fire;
    logic              drain_done;
    logic [IW-1:0]     wr_idx;
    logic [WORDS-1:0]  wr_en;
    logic              num_unused;

    assign idle       = (state_q == ST_IDLE);
    assign clr_fire   = idle && clr;
    assign wr_fire    = idle && en && !clr;
    assign drain_done = (state_q == ST_DRAIN) && !core_busy;

`ifdef KECCAK_COMBINE_AUTOINC_EN
    logic [IW-1:0] ptr_q, ptr_d;

    assign wr_idx     = num[4] ? ptr_q : num[3:0];
    assign num_unused = num[5];

    // Pointer wraps naturally at the index width (15 -> 0).
    always_comb begin
        ptr_d = ptr_q;
        if (clr_fire || drain_done) begin
            ptr_d = '0;
        end else if (wr_fire && num[4]) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign wr_idx     = num[3:0];
    assign num_unused = ^num[5:4];
`endif

    // One-hot word write enable, one decoder output per word.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign wr_en[gi] = wr_fire && (wr_idx == IW'(gi));
            assign out512[gi*WW +: WW] = word_q[gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go && !clr)  state_d = ST_FIRE;
            ST_FIRE:                   state_d = ST_ACK;
            ST_ACK:   if (core_busy)   state_d = ST_DRAIN;
            ST_DRAIN: if (!core_busy)  state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            word_d[i] = word_q[i];
            if (clr_fire) begin
                word_d[i] = '0;
            end else if (wr_en[i]) begin
                word_d[i] = in32;
            end
        end

        mask_d = mask_q | wr_en;
        if (clr_fire || drain_done) begin
            mask_d = '0;
        end

        ovf_d = ovf_q;
        if (clr_fire) begin
            ovf_d = 1'b0;
        end else if (en && !idle) begin
            ovf_d = 1'b1;
        end

        // Outputs are registered from the next-state view so they align with the state.
        full_d  = &mask_d;
        start_d = idle && (state_d == ST_FIRE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            full_q  <= 1'b0;
            start_q <= 1'b0;
            ready_q <= 1'b1;
            ovf_q   <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            full_q  <= full_d;
            start_q <= start_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < WORDS; i++) begin
                word_q[i] <= word_d[i];
            end
        end
    end

    assign mask  = mask_q;
    assign full  = full_q;
    assign start = start_q;
    assign ready = ready_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_keccak_combine.sv
// Directed self-checking bench for keccak_combine (both default and auto-increment builds).
module tb_keccak_combine;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [5:0]   num;
    logic [31:0]  in32;
    logic         clr;
    logic         go;
    logic         core_busy;
    logic [511:0] out512;
    logic [15:0]  mask;
    logic         full;
    logic         start;
    logic         ready;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    logic [511:0] exp_blk;

    keccak_combine dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .num       (num),
        .in32      (in32),
        .clr       (clr),
        .go        (go),
        .core_busy (core_busy),
        .out512    (out512),
        .mask      (mask),
        .full      (full),
        .start     (start),
        .ready     (ready),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wr(input logic [5:0] n, input logic [31:0] d);
        en = 1'b1; num = n; in32 = d;
        tick();
        en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; num = '0; in32 = '0;
        clr = 1'b0; go = 1'b0; core_busy = 1'b0;
        exp_blk = '0;
        #1;
        chk("rst_out512", out512, '0);
        chk("rst_mask",   512'(mask), 512'(16'h0000));
        chk("rst_ready",  512'(ready), 512'(1'b1));
        chk("rst_start",  512'(start), 512'(1'b0));
        chk("rst_ovf",    512'(ovf), 512'(1'b0));
        tick(); tick();
        reset = 1'b0;
        tick();

        // Fill all sixteen words, then hand off.
        for (int k = 0; k < 16; k++) begin
            wr(6'(k), 32'hA5A50000 + 32'(k));
            exp_blk[32*k +: 32] = 32'hA5A50000 + 32'(k);
        end
        chk("fill_full",   512'(full), 512'(1'b1));
        chk("fill_mask",   512'(mask), 512'(16'hFFFF));
        chk("fill_out512", out512, exp_blk);
        chk("fill_w15",    512'(out512[511:480]), 512'(32'hA5A5000F));
        chk("pre_go_start", 512'(start), 512'(1'b0));
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("go_start",    512'(start), 512'(1'b1));
        chk("go_ready",    512'(ready), 512'(1'b0));
        tick();
        chk("ack_start",   512'(start), 512'(1'b0));
        core_busy = 1'b1;
        tick();
        core_busy = 1'b0;
        tick();
        chk("t2_ready",    512'(ready), 512'(1'b1));
        chk("t2_mask",     512'(mask), 512'(16'h0000));
        chk("t2_keep",     out512, exp_blk);

        // Single word 3, mask held through a 5-cycle busy window.
        wr(6'd3, 32'h12345678);
        exp_blk[96 +: 32] = 32'h12345678;
        chk("t3_mask_w",   512'(mask), 512'(16'h0008));
        chk("t3_full",     512'(full), 512'(1'b0));
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        core_busy = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        chk("t3_mask_busy",  512'(mask), 512'(16'h0008));
        chk("t3_ready_busy", 512'(ready), 512'(1'b0));
        core_busy = 1'b0;
        tick();
        chk("t3_mask_done",  512'(mask), 512'(16'h0000));
        chk("t3_ready_done", 512'(ready), 512'(1'b1));

        // Write during ACK is dropped and flags overflow; clr in IDLE clears it.
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        wr(6'd5, 32'hDEADBEEF);
        chk("t4_frozen",   out512, exp_blk);
        chk("t4_ovf",      512'(ovf), 512'(1'b1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_clr_busy", out512, exp_blk);
        core_busy = 1'b1;
        tick();
        core_busy = 1'b0;
        tick();
        chk("t4_ovf_sticky", 512'(ovf), 512'(1'b1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_blk = '0;
        chk("t4_ovf_clr",  512'(ovf), 512'(1'b0));
        chk("t4_blk_clr",  out512, exp_blk);

        // en+clr: clear wins. en+go: write lands before start.
        en = 1'b1; num = 6'd7; in32 = 32'hCAFEF00D; clr = 1'b1;
        tick();
        en = 1'b0; clr = 1'b0;
        chk("t5_clr_mask", 512'(mask), 512'(16'h0000));
        chk("t5_clr_blk",  out512, exp_blk);
        en = 1'b1; num = 6'd9; in32 = 32'h0BADC0DE; go = 1'b1;
        tick();
        en = 1'b0; go = 1'b0;
        exp_blk[288 +: 32] = 32'h0BADC0DE;
        chk("t5_go_start", 512'(start), 512'(1'b1));
        chk("t5_go_blk",   out512, exp_blk);
        chk("t5_go_mask",  512'(mask), 512'(16'h0200));
        tick();
        core_busy = 1'b1;
        tick();
        core_busy = 1'b0;
        tick();
        clr = 1'b1; go = 1'b1;
        tick();
        clr = 1'b0; go = 1'b0;
        chk("t5_clrgo_start", 512'(start), 512'(1'b0));
        chk("t5_clrgo_ready", 512'(ready), 512'(1'b1));
        exp_blk = '0;

`ifdef KECCAK_COMBINE_AUTOINC_EN
        // 17 auto-increment writes wrap the pointer; next write goes to word 1.
        for (int i = 1; i <= 17; i++) begin
            wr(6'h10, 32'h1000 + 32'(i));
            exp_blk[32*((i-1)%16) +: 32] = 32'h1000 + 32'(i);
        end
        chk("t6_w0",       512'(out512[31:0]), 512'(32'h00001011));
        wr(6'h10, 32'h00002222);
        exp_blk[32 +: 32] = 32'h00002222;
        chk("t6_ptr1",     out512, exp_blk);
        wr(6'h05, 32'h00003333);
        exp_blk[160 +: 32] = 32'h00003333;
        chk("t6_direct",   out512, exp_blk);
`else
        // num[4] has no effect without auto-increment.
        wr(6'h13, 32'h00004444);
        exp_blk[96 +: 32] = 32'h00004444;
        chk("t6_num4_ign", out512, exp_blk);
        chk("t6_num4_mask", 512'(mask), 512'(16'h0008));
`endif

        // Async reset: start drops without waiting for a clock edge.
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("t7_start_pre", 512'(start), 512'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        chk("t7_start_rst", 512'(start), 512'(1'b0));
        chk("t7_ready_rst", 512'(ready), 512'(1'b1));
        chk("t7_blk_rst",   out512, '0);
        tick();
        reset = 1'b0;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        chk("t7_ack_ready", 512'(ready), 512'(1'b0));
        reset = 1'b1;
        #1;
        chk("t7_ack_rst_ready", 512'(ready), 512'(1'b1));
        chk("t7_ack_rst_start", 512'(start), 512'(1'b0));
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
